bus_split_arbiter: RTL and testbench

// Serial-bus arbiter granting one of N_INIT initiators (e.g. CPU-side master, bus_bridge initiator side) bus ownership.

---
 rtl/bus_split_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_split_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_split_arbiter.sv
// Round-robin bus arbiter with split-transaction parking and a per-tenure watchdog.
// One initiator owns the bus at a time; a split-parked initiator is resumed when its target calls back.
module bus_split_arbiter #(
  parameter int N_INIT         = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INIT-1:0]         req_i,
  input  logic                      bus_ack_i,
  input  logic                      bus_split_ack_i,
  input  logic                      split_req_i,
  output logic [N_INIT-1:0]         grant_o,
  output logic                      split_grant_o,
  output logic [$clog2(N_INIT)-1:0] owner_id_o,
  output logic                      bus_busy_o,
  output logic                      timeout_pulse_o
);

  localparam int IW = $clog2(N_INIT);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t              state_q;
  logic [N_INIT-1:0]   grant_q;
  logic                split_grant_q;
  logic [IW-1:0]       owner_q;
  logic                busy_q;
  logic                timeout_q;
  logic [IW-1:0]       rr_ptr_q;
  logic                split_pending_q;
  logic [IW-1:0]       split_owner_q;
  logic [TW-1:0]       timer_q;

  logic [N_INIT-1:0]   park_mask;
  logic [N_INIT-1:0]   eligible;
  logic [2*N_INIT-1:0] eligible_dbl;
  logic [N_INIT-1:0]   eligible_rot;
  logic                arb_found;
  int                  arb_sum;
  logic [IW-1:0]       arb_win;
  logic [IW-1:0]       rr_ptr_d;
  logic                wd_hit;
  logic                owner_req;

  assign park_mask    = split_pending_q ? (N_INIT'(1) << split_owner_q) : '0;
  assign eligible     = req_i & ~park_mask;
  assign eligible_dbl = {eligible, eligible};
  // Rotate so bit 0 corresponds to the round-robin pointer; first set bit wins.
  assign eligible_rot = N_INIT'(eligible_dbl >> rr_ptr_q);

  always_comb begin
    arb_found = 1'b0;
    arb_sum   = 0;
    for (int k = N_INIT - 1; k >= 0; k--) begin
      if (eligible_rot[k]) begin
        arb_found = 1'b1;
        arb_sum   = k;
      end
    end
    arb_sum = arb_sum + int'(rr_ptr_q);
    if (arb_sum >= N_INIT) arb_sum = arb_sum - N_INIT;
    arb_win = IW'(arb_sum);
  end

  assign rr_ptr_d  = (arb_win == IW'(N_INIT - 1)) ? '0 : arb_win + 1'b1;
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && (timer_q == TMAX);
  assign owner_req = req_i[owner_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      split_grant_q   <= 1'b0;
      owner_q         <= '0;
      busy_q          <= 1'b0;
      timeout_q       <= 1'b0;
      rr_ptr_q        <= '0;
      split_pending_q <= 1'b0;
      split_owner_q   <= '0;
      timer_q         <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (split_pending_q && split_req_i) begin
            state_q       <= RESUME;
            grant_q       <= N_INIT'(1) << split_owner_q;
            split_grant_q <= 1'b1;
            owner_q       <= split_owner_q;
            busy_q        <= 1'b1;
          end else if (arb_found) begin
            state_q  <= BUSY;
            grant_q  <= N_INIT'(1) << arb_win;
            owner_q  <= arb_win;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (bus_ack_i || bus_split_ack_i || !owner_req || wd_hit) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            split_grant_q <= 1'b0;
            busy_q        <= 1'b0;
            timer_q       <= '0;
            // Completion beats split when both arrive together.
            if (!bus_ack_i && bus_split_ack_i) begin
              split_pending_q <= 1'b1;
              split_owner_q   <= owner_q;
            end
            if (!bus_ack_i && !bus_split_ack_i && owner_req) timeout_q <= 1'b1;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESUME: begin
          if (bus_ack_i || wd_hit) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            split_grant_q   <= 1'b0;
            busy_q          <= 1'b0;
            timer_q         <= '0;
            split_pending_q <= 1'b0;
            if (!bus_ack_i) timeout_q <= 1'b1;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_q       <= '0;
          split_grant_q <= 1'b0;
          busy_q        <= 1'b0;
          timer_q       <= '0;
        end
      endcase
    end
  end

  assign grant_o         = grant_q;
  assign split_grant_o   = split_grant_q;
  assign owner_id_o      = owner_q;
  assign bus_busy_o      = busy_q;
  assign timeout_pulse_o = timeout_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios followed by random traffic,
// all checked against a tenure-level behavioural model.
module tb_bus_split_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic         sack = 1'b0;
  logic         sreq = 1'b0;
  logic [N-1:0] grant;
  logic         split_grant;
  logic [1:0]   owner_id;
  logic         bus_busy;
  logic         tpulse;

  int checks = 0;
  int errors = 0;

  // Model: who holds the bus, what kind of tenure, how long it has lasted.
  int m_kind   = 0;   // 0 none, 1 normal tenure, 2 split response
  int m_owner  = 0;
  int m_parked = -1;  // initiator waiting on a split, -1 if none
  int m_age    = 0;
  int m_rr     = 0;
  bit m_tp     = 0;

  bus_split_arbiter #(.N_INIT(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .bus_ack_i       (ack),
    .bus_split_ack_i (sack),
    .split_req_i     (sreq),
    .grant_o         (grant),
    .split_grant_o   (split_grant),
    .owner_id_o      (owner_id),
    .bus_busy_o      (bus_busy),
    .timeout_pulse_o (tpulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_kind = 0; m_owner = 0; m_parked = -1; m_age = 0; m_rr = 0; m_tp = 0;
      return;
    end
    m_tp = 0;
    if (m_kind == 0) begin
      if (m_parked >= 0 && sreq) begin
        m_kind = 2; m_owner = m_parked; m_age = 0;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (req[idx] && idx != m_parked) begin
            m_kind = 1; m_owner = idx; m_rr = (idx + 1) % N; m_age = 0;
            break;
          end
        end
      end
    end else if (m_kind == 1) begin
      if (ack) m_kind = 0;
      else if (sack) begin m_parked = m_owner; m_kind = 0; end
      else if (!req[m_owner]) m_kind = 0;
      else if (m_age == TO - 1) begin m_kind = 0; m_tp = 1; end
      else m_age++;
    end else begin
      if (ack) begin m_parked = -1; m_kind = 0; end
      else if (m_age == TO - 1) begin m_parked = -1; m_kind = 0; m_tp = 1; end
      else m_age++;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_kind != 0) ? N'(1 << m_owner) : '0;
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_split_grant", 32'(split_grant), 32'(m_kind == 2));
    chk("m_owner_id", 32'(owner_id), 32'(m_owner));
    chk("m_bus_busy", 32'(bus_busy), 32'(m_kind != 0));
    chk("m_timeout", 32'(tpulse), 32'(m_tp));
  endtask

  task automatic step(input logic [N-1:0] r, input logic a, input logic sa, input logic sr);
    req = r; ack = a; sack = sa; sreq = sr;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step(3'b000, 0, 0, 0);
    step(3'b011, 0, 0, 0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    rst_n = 1'b1;

    // Round robin with one dead cycle between tenures
    step(3'b011, 0, 0, 0); chk("rr_first", 32'(grant), 32'h1);
    step(3'b011, 1, 0, 0); chk("rr_gap1", 32'(grant), 32'h0);
    step(3'b011, 0, 0, 0); chk("rr_second", 32'(grant), 32'h2);
    step(3'b011, 1, 0, 0); chk("rr_gap2", 32'(grant), 32'h0);
    step(3'b011, 0, 0, 0); chk("rr_third", 32'(grant), 32'h1);

    // Split: init0 parked, init1 served, then resume
    step(3'b011, 0, 1, 0); chk("split_drop", 32'(grant), 32'h0);
    step(3'b011, 0, 0, 0); chk("masked_g1", 32'(grant), 32'h2);
    chk("masked_owner", 32'(owner_id), 32'h1);
    step(3'b011, 1, 0, 0);
    step(3'b011, 0, 0, 0); chk("masked_g2", 32'(grant), 32'h2);
    step(3'b011, 1, 0, 0);
    step(3'b011, 0, 0, 1); chk("resume_grant", 32'(grant), 32'h1);
    chk("resume_sg", 32'(split_grant), 32'h1);
    step(3'b011, 1, 0, 0); chk("resume_end_sg", 32'(split_grant), 32'h0);
    chk("resume_end_g", 32'(grant), 32'h0);

    // split_req while another initiator is busy waits, then beats pending req
    step(3'b011, 0, 0, 0); chk("s3_g0", 32'(grant), 32'h1);
    step(3'b011, 0, 1, 0);
    step(3'b011, 0, 0, 0); chk("s3_g1", 32'(grant), 32'h2);
    step(3'b011, 0, 0, 1); chk("s3_hold", 32'(grant), 32'h2);
    chk("s3_hold_sg", 32'(split_grant), 32'h0);
    step(3'b011, 1, 0, 1); chk("s3_gap", 32'(grant), 32'h0);
    step(3'b011, 0, 0, 1); chk("s3_resume", 32'(grant), 32'h1);
    chk("s3_resume_sg", 32'(split_grant), 32'h1);
    step(3'b011, 1, 0, 0);

    // Watchdog: 8 cycles of grant, then a single timeout pulse
    step(3'b100, 0, 0, 0); chk("wd_g0", 32'(grant), 32'h4);
    for (int i = 1; i < TO; i++) begin
      step(3'b100, 0, 0, 0);
      chk("wd_hold", 32'(grant), 32'h4);
      chk("wd_nopulse", 32'(tpulse), 32'h0);
    end
    step(3'b100, 0, 0, 0); chk("wd_drop", 32'(grant), 32'h0);
    chk("wd_pulse", 32'(tpulse), 32'h1);
    step(3'b000, 0, 0, 0); chk("wd_pulse_end", 32'(tpulse), 32'h0);

    // Simultaneous ack and split ack completes without parking
    step(3'b001, 0, 0, 0); chk("both_g", 32'(grant), 32'h1);
    step(3'b001, 1, 1, 0); chk("both_drop", 32'(grant), 32'h0);
    step(3'b001, 0, 0, 0); chk("both_noprk", 32'(grant), 32'h1);
    step(3'b001, 1, 0, 0);

    // Reset in the middle of a split response
    step(3'b001, 0, 0, 0);
    step(3'b001, 0, 1, 0);
    step(3'b000, 0, 0, 1); chk("r5_sg", 32'(split_grant), 32'h1);
    rst_n = 1'b0;
    step(3'b000, 0, 0, 0);
    chk("r5_grant", 32'(grant), 32'h0);
    chk("r5_sg0", 32'(split_grant), 32'h0);
    chk("r5_busy", 32'(bus_busy), 32'h0);
    chk("r5_owner", 32'(owner_id), 32'h0);
    rst_n = 1'b1;
    step(3'b000, 0, 0, 1); chk("r5_nopark", 32'(split_grant), 32'h0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] r;
      r = req;
      if ($urandom_range(0, 5) == 0) r = N'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step(r, $urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0,
           $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
